// File: rtl/fwd_hazard_if.sv
// Consumer-side bundle for the forwarding/hazard controller: decode-stage
// operand info and pipeline controls in, forwarding selects and stall controls out.
interface fwd_hazard_if #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_W   = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 32
) ();
    logic                       id_valid;
    logic [NUM_SRC*REG_W-1:0]   id_rs_addr;
    logic [NUM_SRC-1:0]         id_rs_used;
    logic [REG_W-1:0]           id_rd_addr;
    logic                       id_rd_we;
    logic [SEL_W-1:0]           id_rdy_stage;
    logic                       pipe_freeze;
    logic                       flush;
    logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
    logic                       stall;
    logic                       bubble;
    logic [CNT_W-1:0]           stall_count;

    modport master (
        output id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we,
               id_rdy_stage, pipe_freeze, flush,
        input  fwd_sel, stall, bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs_addr, id_rs_used, id_rd_addr, id_rd_we,
               id_rdy_stage, pipe_freeze, flush,
        output fwd_sel, stall, bubble, stall_count
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: a shift-register scoreboard of
// in-flight destinations drives per-operand forwarding selects and stall/bubble.
module fwd_hazard_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_W   = 5,
    parameter int SEL_W   = $clog2(DEPTH + 1),
    parameter int CNT_W   = 32
) (
    input  logic         clk,
    input  logic         rst,
    fwd_hazard_if.slave  bus
);

    typedef struct packed {
        logic             vld;
        logic [REG_W-1:0] rd;
        logic [SEL_W-1:0] rdy;
    } entry_t;

    // Index 1 is the stage immediately ahead of the consumer.
    entry_t entry_q [1:DEPTH];
    entry_t entry_d [1:DEPTH];

    logic [CNT_W-1:0]         stall_count_q;
    logic [CNT_W-1:0]         stall_count_d;

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_w;
    logic [NUM_SRC-1:0]       nrdy_w;
    logic                     stall_w;
    logic                     bubble_w;
    logic [SEL_W-1:0]         rdy_in;

    // ------------------------------------------------------------------
    // Per-operand lookup: the nearest matching producer decides the
    // outcome, so an older ready copy never overrides a younger pending one.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_op
            logic [REG_W-1:0] rs;
            logic             active;
            logic [SEL_W-1:0] sel;
            logic             nrdy;
            logic             hit;

            assign rs     = bus.id_rs_addr[gi*REG_W +: REG_W];
            assign active = bus.id_valid & bus.id_rs_used[gi] & (rs != '0);

            always_comb begin
                sel  = '0;
                nrdy = 1'b0;
                hit  = 1'b0;
                for (int s = 1; s <= DEPTH; s++) begin
                    if (active && !hit && entry_q[s].vld && (entry_q[s].rd == rs)) begin
                        hit = 1'b1;
                        if (SEL_W'(s) >= entry_q[s].rdy) begin
                            sel = SEL_W'(s);
                        end else begin
                            nrdy = 1'b1;
                        end
                    end
                end
            end

            assign fwd_sel_w[gi*SEL_W +: SEL_W] = sel;
            assign nrdy_w[gi]                   = nrdy;
        end
    endgenerate

    assign stall_w  = bus.id_valid & ~bus.flush & (|nrdy_w);
    assign bubble_w = stall_w & ~bus.pipe_freeze;

    // Out-of-range ready stages are clamped so every entry eventually forwards.
    always_comb begin
        rdy_in = bus.id_rdy_stage;
        if (bus.id_rdy_stage == '0) begin
            rdy_in = SEL_W'(1);
        end else if (bus.id_rdy_stage > SEL_W'(DEPTH)) begin
            rdy_in = SEL_W'(DEPTH);
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard advance and stall counter
    // ------------------------------------------------------------------
    always_comb begin
        entry_d       = entry_q;
        stall_count_d = stall_count_q;
        if (!bus.pipe_freeze) begin
            for (int s = DEPTH; s >= 2; s--) begin
                entry_d[s] = entry_q[s-1];
            end
            if (stall_w || bus.flush || !bus.id_valid) begin
                entry_d[1] = '0;
            end else begin
                entry_d[1].vld = bus.id_rd_we & (bus.id_rd_addr != '0);
                entry_d[1].rd  = bus.id_rd_addr;
                entry_d[1].rdy = rdy_in;
            end
            if (stall_w && (stall_count_q != '1)) begin
                stall_count_d = stall_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 1; s <= DEPTH; s++) begin
                entry_q[s] <= '0;
            end
            stall_count_q <= '0;
        end else begin
            for (int s = 1; s <= DEPTH; s++) begin
                entry_q[s] <= entry_d[s];
            end
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.fwd_sel     = fwd_sel_w;
    assign bus.stall       = stall_w;
    assign bus.bubble      = bubble_w;
    assign bus.stall_count = stall_count_q;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and load-use hazard controller for the pipelined RV32I core.
- Generalises the fixed 2-bit forwarding selects to any number of source operands and any number of producer stages.
- Keeps an internal shift-register scoreboard of in-flight destination registers.
- Drives forwarding-mux selects, stall, and bubble-injection signals for the consumer stage (decode/execute boundary).

Parameters:
NUM_SRC, 2, number of source operands resolved per consumer instruction
DEPTH, 3, number of tracked producer stages ahead of the consumer (stage 1 = nearest)
REG_W, 5, register address width
SEL_W, $clog2(DEPTH+1), width of each forwarding select
CNT_W, 32, stall performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
id_valid  in  1  consumer instruction present
id_rs_addr  in  NUM_SRC*REG_W  source register addresses, operand i at bits [i*REG_W +: REG_W]
id_rs_used  in  NUM_SRC  operand i actually read
id_rd_addr  in  REG_W  consumer destination register
id_rd_we  in  1  consumer writes rd
id_rdy_stage  in  SEL_W  first stage (1..DEPTH) at which consumer result is forwardable (ALU=1, load=2)
pipe_freeze  in  1  global freeze (cache miss); scoreboard holds
flush  in  1  kill consumer instruction (branch redirect)
fwd_sel  out  NUM_SRC*SEL_W  per-operand select: 0 = regfile, s = forward from stage s
stall  out  1  hold consumer and upstream stages
bubble  out  1  insert nop into stage 1 this cycle
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Scoreboard: entries 1..DEPTH, each {valid, rd, rdy}.
  - valid is set only when we=1 and rd!=0.
  - rdy is the stage index at which the result becomes forwardable.
- Reset: all entries invalid, stall_count=0.
  - Consequently fwd_sel=0, stall=0, bubble=0 in the cycle after rst.
- Select (combinational from scoreboard and id_*), for each operand i with id_valid & id_rs_used[i] & rs!=0:
  - Find the smallest s with entry[s].valid and entry[s].rd==rs[i].
  - No match -> fwd_sel[i]=0.
  - Match and s >= entry[s].rdy -> fwd_sel[i]=s.
  - Match and s < entry[s].rdy -> operand not ready, fwd_sel[i]=0.
- Nearest producer always wins; older matches are ignored even if ready.
- rs=0 or operand unused -> fwd_sel[i]=0, never stalls.
- stall = id_valid & !flush & (any operand not ready). Combinational.
- bubble = stall & !pipe_freeze.
- Update on each rising clk when !rst, in priority order:
  - pipe_freeze=1: all entries hold.
  - Otherwise entry[s+1] <= entry[s] for s=1..DEPTH-1; entry[DEPTH] retires and is dropped.
  - Then, if stall or flush or !id_valid: entry[1] <= invalid.
  - Otherwise entry[1] <= {id_rd_we & rd!=0, id_rd_addr, id_rdy_stage}.
- Retired entries are read from the regfile. The regfile is write-through, so no extra stage is needed.
- id_rdy_stage = 0 is treated as 1; values > DEPTH are treated as DEPTH.
- Stall resolution: a load at stage 1 with rdy=2 stalls a dependent consumer exactly one cycle (absent freeze). On the next cycle the load is at stage 2 and fwd_sel=2.
- stall_count increments by 1 on each clk where stall=1 and pipe_freeze=0. It saturates at all-ones.
- flush and stall together: flush wins; stall=0 and entry[1] gets a bubble.
- rst mid-operation: scoreboard cleared next cycle regardless of freeze; stall_count cleared.

Test Plan:
1. ALU to ALU back-to-back: issue add x5 (rdy=1), then sub reading x5 as op0 -> fwd_sel[0]=1, stall=0. Next cycle a consumer reading x5 -> fwd_sel[0]=2.
2. Load-use: lw x6 (rdy=2), then add reading x6 as op1 -> stall=1 and bubble=1 for exactly 1 cycle, then fwd_sel[1]=2, stall_count=1.
3. Double producer: add x7 at stage 2 and add x7 at stage 1, consumer reads x7 -> fwd_sel=1 (nearest wins).
4. x0 and unused operands: producer writes x0, consumer reads x0 with id_rs_used=0b11 -> fwd_sel=0, stall=0, entry not valid.
5. Freeze during load-use: lw x8, consumer reads x8, pipe_freeze=1 for 3 cycles -> stall=1, bubble=0, stall_count unchanged, scoreboard held. On release, 1 stall cycle, then fwd_sel=2.
6. Flush and reset: flush=1 with a consumer writing x9 -> the next consumer reading x9 gets fwd_sel=0. rst asserted with 3 valid entries -> next cycle all fwd_sel=0, stall_count=0.
